// File: rtl/coin_input_pkg.sv
// Shared definitions for the coin/control input conditioning block.
//   coin_state_t : coin pulse generator states
//   ctl_bit_e    : bit layout of a player control bus {trig2,trig1,left,down,right,up}
//   inp2_bit_e   : bit layout of the INP2 bus {coin, start2, start1}
package coin_input_pkg;

  localparam int CTL_W = 6;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  typedef enum int unsigned {
    CTL_UP    = 0,
    CTL_RIGHT = 1,
    CTL_DOWN  = 2,
    CTL_LEFT  = 3,
    CTL_TRIG1 = 4,
    CTL_TRIG2 = 5
  } ctl_bit_e;

  typedef enum int unsigned {
    INP2_START1 = 0,
    INP2_START2 = 1,
    INP2_COIN   = 2
  } inp2_bit_e;

endpackage

// File: rtl/input_debounce.sv
// Vectorised synchroniser + debouncer.
//   clk, rst : clock, synchronous active-high reset
//   tick     : sample strobe, one cycle wide
//   raw      : asynchronous inputs
//   stable   : debounced outputs (registered)
// Each bit is synchronised by two flops, sampled into a DEB_N-deep history on
// every tick, and the stable value follows once the whole history agrees.
module input_debounce #(
  parameter int W     = 16,
  parameter int DEB_N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);

  logic [W-1:0]            sync1, sync2;
  logic [W-1:0][DEB_N-1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      hist   <= '0;
      stable <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < W; i++) begin
        if (tick)
          hist[i] <= {hist[i][DEB_N-2:0], sync2[i]};
        // history only moves on ticks, so this settles the cycle after one
        if (&hist[i])
          stable[i] <= 1'b1;
        else if (~|hist[i])
          stable[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/coin_input_cond.sv
// Input conditioning between the key/joystick merge and the game core.
//   MCLK, RESET        : clock, synchronous active-high reset
//   IN0_RAW, IN1_RAW   : raw P1/P2 controls {trig2,trig1,left,down,right,up}
//   START_RAW          : raw {start2,start1}
//   COIN_RAW           : raw {coin2,coin1}
//   INP0, INP1         : debounced P1/P2 controls
//   INP2               : {coin_pulse, start2, start1}
//   COIN_PEND          : coins queued and not yet pulsed
//   COIN_OVF           : sticky, a coin was dropped on a full queue
// Coin presses are counted into a saturating queue and replayed as a train of
// fixed-width pulses separated by a fixed gap, so no press is merged or lost.
module coin_input_cond
  import coin_input_pkg::*;
#(
  parameter int TICK_DIV    = 48000,
  parameter int DEB_N       = 4,
  parameter int PULSE_TICKS = 100,
  parameter int GAP_TICKS   = 100,
  parameter int QBITS       = 4
) (
  input  logic             MCLK,
  input  logic             RESET,
  input  logic [5:0]       IN0_RAW,
  input  logic [5:0]       IN1_RAW,
  input  logic [1:0]       START_RAW,
  input  logic [1:0]       COIN_RAW,
  output logic [5:0]       INP0,
  output logic [5:0]       INP1,
  output logic [2:0]       INP2,
  output logic [QBITS-1:0] COIN_PEND,
  output logic             COIN_OVF
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int SW   = QBITS + 2;

  localparam logic [PW-1:0]    TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0]    PULSE_LAST = TW'(PULSE_TICKS - 1);
  localparam logic [TW-1:0]    GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [QBITS-1:0] PEND_MAX   = '1;

  // ---------------- tick prescaler ----------------
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == TICK_LAST);

  always_ff @(posedge MCLK) begin
    if (RESET)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  // ---------------- debounce ----------------
  logic [15:0] db;

  input_debounce #(.W(16), .DEB_N(DEB_N)) u_deb (
    .clk    (MCLK),
    .rst    (RESET),
    .tick   (tick),
    .raw    ({COIN_RAW, START_RAW, IN1_RAW, IN0_RAW}),
    .stable (db)
  );

  logic [1:0] coin_db, start_db;
  assign INP0     = db[CTL_W-1:0];
  assign INP1     = db[2*CTL_W-1:CTL_W];
  assign start_db = db[2*CTL_W+1:2*CTL_W];
  assign coin_db  = db[2*CTL_W+3:2*CTL_W+2];

  // ---------------- coin queue ----------------
  logic [1:0]       coin_prev, rise, inc;
  logic [QBITS-1:0] pend;
  logic [SW-1:0]    pend_sum;
  logic             ovf, dec;

  assign rise     = coin_db & ~coin_prev;
  assign inc      = {1'b0, rise[0]} + {1'b0, rise[1]};
  // wide enough that pend + 2 never wraps before the saturation test
  assign pend_sum = SW'(pend) + SW'(inc) - SW'(dec);

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      coin_prev <= '0;
      pend      <= '0;
      ovf       <= 1'b0;
    end else begin
      coin_prev <= coin_db;
      if (pend_sum > SW'(PEND_MAX)) begin
        pend <= PEND_MAX;
        ovf  <= 1'b1;
      end else begin
        pend <= pend_sum[QBITS-1:0];
      end
    end
  end

  // ---------------- coin pulse FSM ----------------
  coin_state_t   state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          coin_pulse;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state <= IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE: begin
        if (pend != '0) begin
          state_nxt = PULSE;
          tcnt_nxt  = '0;
        end
      end
      PULSE: begin
        if (tick) begin
          if (tcnt == PULSE_LAST) begin
            state_nxt = GAP;
            tcnt_nxt  = '0;
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (tcnt == GAP_LAST) begin
            state_nxt = (pend != '0) ? PULSE : IDLE;
            tcnt_nxt  = '0;
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tcnt_nxt  = '0;
      end
    endcase
  end

  // a coin leaves the queue the moment its pulse starts
  always_comb begin
    coin_pulse = (state == PULSE);
    dec        = (state_nxt == PULSE) && (state != PULSE);
  end

  assign INP2      = {coin_pulse, start_db};
  assign COIN_PEND = pend;
  assign COIN_OVF  = ovf;

endmodule

// File: tb/tb_coin_input_cond.sv
module tb_coin_input_cond;
  import coin_input_pkg::*;

  localparam int TICK_DIV = 4, DEB_N = 3, PULSE_TICKS = 2, GAP_TICKS = 2, QBITS = 4;

  logic             MCLK = 1'b0;
  logic             RESET = 1'b1;
  logic [5:0]       IN0_RAW = '0, IN1_RAW = '0;
  logic [1:0]       START_RAW = '0, COIN_RAW = '0;
  logic [5:0]       INP0, INP1;
  logic [2:0]       INP2;
  logic [QBITS-1:0] COIN_PEND;
  logic             COIN_OVF;

  coin_input_cond #(
    .TICK_DIV(TICK_DIV), .DEB_N(DEB_N), .PULSE_TICKS(PULSE_TICKS),
    .GAP_TICKS(GAP_TICKS), .QBITS(QBITS)
  ) dut (
    .MCLK(MCLK), .RESET(RESET), .IN0_RAW(IN0_RAW), .IN1_RAW(IN1_RAW),
    .START_RAW(START_RAW), .COIN_RAW(COIN_RAW), .INP0(INP0), .INP1(INP1),
    .INP2(INP2), .COIN_PEND(COIN_PEND), .COIN_OVF(COIN_OVF)
  );

  always #5 MCLK = ~MCLK;

  int errors = 0;
  int checks = 0;

  // pulse-train observer: records widths/gaps, the checks happen in the tasks
  logic             stats_clr = 1'b0;
  logic             prev_coin = 1'b0;
  int               pulse_cnt = 0, hi_len = 0, lo_len = 0;
  int               min_hi = 999, max_hi = 0, min_gap = 999;
  logic             seen_pulse = 1'b0;
  logic [QBITS-1:0] max_pend = '0;

  always @(posedge MCLK) begin
    if (stats_clr) begin
      pulse_cnt  <= 0; hi_len <= 0; lo_len <= 0;
      min_hi     <= 999; max_hi <= 0; min_gap <= 999;
      seen_pulse <= 1'b0; max_pend <= '0; prev_coin <= INP2[2];
    end else begin
      if (INP2[2]) begin
        hi_len <= prev_coin ? hi_len + 1 : 1;
        if (!prev_coin) begin
          pulse_cnt <= pulse_cnt + 1;
          if (seen_pulse && lo_len < min_gap) min_gap <= lo_len;
        end
      end else begin
        lo_len <= prev_coin ? 1 : lo_len + 1;
        if (prev_coin) begin
          seen_pulse <= 1'b1;
          if (hi_len < min_hi) min_hi <= hi_len;
          if (hi_len > max_hi) max_hi <= hi_len;
        end
      end
      prev_coin <= INP2[2];
      if (COIN_PEND > max_pend) max_pend <= COIN_PEND;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  task automatic clr_stats;
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
  endtask

  task automatic press(input logic [1:0] mask, input int hi, input int lo);
    COIN_RAW = mask;
    step(hi);
    COIN_RAW = 2'b00;
    step(lo);
  endtask

  // waits for an empty queue followed by 20 quiet cycles
  task automatic drain(input int bound, output bit ok);
    int quiet = 0;
    for (int c = 0; c < bound && quiet < 20; c++) begin
      step(1);
      if (COIN_PEND == 0 && !INP2[2]) quiet++;
      else quiet = 0;
    end
    ok = (quiet >= 20);
  endtask

  task automatic test_reset;
    int lat = -1;
    RESET = 1'b1; IN0_RAW = 6'h3F;
    step(4);
    checks++; if (INP0 !== 6'h00) begin errors++; $display("FAIL reset_inp0: got %h want 00", INP0); end
    checks++; if (INP1 !== 6'h00) begin errors++; $display("FAIL reset_inp1: got %h want 00", INP1); end
    checks++; if (INP2 !== 3'b000) begin errors++; $display("FAIL reset_inp2: got %b want 000", INP2); end
    checks++; if (COIN_PEND !== 4'd0 || COIN_OVF !== 1'b0) begin
      errors++; $display("FAIL reset_queue: got pend=%0d ovf=%b want 0/0", COIN_PEND, COIN_OVF); end
    RESET = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      if (lat < 0 && INP0 === 6'h3F) lat = k;
    end
    checks++; if (lat < 0) begin errors++; $display("FAIL reset_latency: INP0=%h after 15 cycles want 3f", INP0); end
  endtask

  task automatic test_glitch;
    int leak = 0;
    IN0_RAW = 6'h00;
    step(20);
    checks++; if (INP0 !== 6'h00) begin errors++; $display("FAIL glitch_settle: got %h want 00", INP0); end
    IN0_RAW[0] = 1'b1;
    step(5);
    IN0_RAW[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (INP0[0] !== 1'b0) leak++;
    end
    checks++; if (leak != 0) begin errors++; $display("FAIL glitch_filtered: %0d cycles high want 0", leak); end
    IN0_RAW[0] = 1'b1;
    step(20);
    checks++; if (INP0[0] !== 1'b1) begin errors++; $display("FAIL glitch_sustained: got %b want 1", INP0[0]); end
    IN0_RAW = 6'h00;
    step(20);
  endtask

  // reference: bits that do not change between targets must never move,
  // and after a long hold the output equals the target
  task automatic test_random_ctl;
    logic [5:0] v, n, g;
    int gl, bad;
    v = 6'h00;
    for (int it = 0; it < 8; it++) begin
      n = 6'($urandom); g = 6'($urandom); gl = $urandom_range(1, 5);
      bad = 0;
      IN1_RAW = v ^ g;
      for (int c = 0; c < gl; c++) begin
        step(1);
        if (((INP1 ^ v) & ~(v ^ n)) != 0) bad++;
      end
      IN1_RAW = n;
      for (int c = 0; c < 20; c++) begin
        step(1);
        if (((INP1 ^ v) & ~(v ^ n)) != 0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL ctl_stable_bits: %0d bad cycles (v=%h n=%h g=%h) want 0", bad, v, n, g); end
      checks++; if (INP1 !== n) begin errors++; $display("FAIL ctl_settle: got %h want %h", INP1, n); end
      v = n;
    end
  endtask

  task automatic test_single_coin;
    bit ok;
    clr_stats();
    press(2'b01, 40, 0);
    drain(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain: pend=%0d after bound want 0", COIN_PEND); end
    checks++; if (pulse_cnt != 1) begin errors++; $display("FAIL single_count: got %0d pulses want 1", pulse_cnt); end
    checks++; if (min_hi < 4 || max_hi > 8) begin errors++; $display("FAIL single_width: got %0d..%0d want 4..8", min_hi, max_hi); end
    checks++; if (lo_len < 7) begin errors++; $display("FAIL single_low: got %0d want >=7", lo_len); end
    checks++; if (max_pend != 1) begin errors++; $display("FAIL single_pend: peak %0d want 1", max_pend); end
  endtask

  task automatic test_dual_coin;
    bit ok;
    clr_stats();
    press(2'b11, 40, 0);
    drain(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dual_drain: pend=%0d after bound want 0", COIN_PEND); end
    checks++; if (max_pend != 2) begin errors++; $display("FAIL dual_pend: peak %0d want 2", max_pend); end
    checks++; if (pulse_cnt != 2) begin errors++; $display("FAIL dual_count: got %0d pulses want 2", pulse_cnt); end
    checks++; if (min_gap < 7) begin errors++; $display("FAIL dual_gap: got %0d want >=7", min_gap); end
    checks++; if (min_hi < 4 || max_hi > 8) begin errors++; $display("FAIL dual_width: got %0d..%0d want 4..8", min_hi, max_hi); end
  endtask

  // reference: every debounced press of each coin bit yields exactly one pulse
  task automatic test_random_coins;
    bit ok;
    int n, expected;
    logic [1:0] mask;
    for (int r = 0; r < 3; r++) begin
      clr_stats();
      n = $urandom_range(2, 5);
      expected = 0;
      for (int p = 0; p < n; p++) begin
        mask = 2'($urandom_range(1, 3));
        expected += int'(mask[0]) + int'(mask[1]);
        press(mask, $urandom_range(12, 16), $urandom_range(12, 20));
      end
      drain(500, ok);
      checks++; if (!ok || pulse_cnt != expected) begin
        errors++; $display("FAIL rand_coin_count: got %0d pulses (drained=%0d) want %0d", pulse_cnt, ok, expected); end
      checks++; if (min_hi < 4 || max_hi > 8 || (expected > 1 && min_gap < 7)) begin
        errors++; $display("FAIL rand_coin_shape: width %0d..%0d gap %0d want 4..8 / >=7", min_hi, max_hi, min_gap); end
      checks++; if (COIN_OVF !== 1'b0) begin errors++; $display("FAIL rand_coin_ovf: got %b want 0", COIN_OVF); end
    end
  endtask

  // fastest debounceable presses on both bits outrun the pulse train
  task automatic test_saturation;
    bit ok, found;
    found = 1'b0;
    clr_stats();
    for (int p = 0; p < 80 && !found; p++) begin
      COIN_RAW = 2'b11;
      for (int c = 0; c < 24; c++) begin
        if (c == 12) COIN_RAW = 2'b00;
        step(1);
        if (COIN_PEND == 4'd15) found = 1'b1;
      end
    end
    press(2'b11, 12, 12);
    press(2'b11, 12, 12);
    checks++; if (!found || max_pend != 4'd15) begin errors++; $display("FAIL sat_peak: got %0d want 15", max_pend); end
    checks++; if (COIN_OVF !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", COIN_OVF); end
    drain(800, ok);
    checks++; if (!ok || COIN_PEND !== 4'd0) begin errors++; $display("FAIL sat_drain: pend=%0d want 0", COIN_PEND); end
    checks++; if (COIN_OVF !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky: got %b want 1", COIN_OVF); end
    checks++; if (pulse_cnt < 15) begin errors++; $display("FAIL sat_pulses: got %0d want >=15", pulse_cnt); end
  endtask

  task automatic test_reset_mid_pulse;
    bit found;
    found = 1'b0;
    for (int p = 0; p < 40 && !found; p++) begin
      COIN_RAW = 2'b11;
      for (int c = 0; c < 24 && !found; c++) begin
        if (c == 12) COIN_RAW = 2'b00;
        step(1);
        if (COIN_PEND == 4'd3 && INP2[2] === 1'b1) found = 1'b1;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_setup: pend=3 during pulse not reached, pend=%0d", COIN_PEND); end
    RESET = 1'b1; COIN_RAW = 2'b00;
    step(1);
    checks++; if (INP2[2] !== 1'b0) begin errors++; $display("FAIL midrst_pulse: got %b want 0", INP2[2]); end
    checks++; if (COIN_PEND !== 4'd0 || COIN_OVF !== 1'b0) begin
      errors++; $display("FAIL midrst_queue: got pend=%0d ovf=%b want 0/0", COIN_PEND, COIN_OVF); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d want IDLE", dut.state); end
    RESET = 1'b0;
    clr_stats();
    step(40);
    checks++; if (pulse_cnt != 0 || COIN_PEND !== 4'd0) begin
      errors++; $display("FAIL midrst_residual: got %0d pulses pend=%0d want 0/0", pulse_cnt, COIN_PEND); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_random_ctl();
    test_single_coin();
    test_dual_coin();
    test_random_coins();
    test_saturation();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/coin_input_cond.md
Name: coin_input_cond

Overview:
Input conditioning stage between the keyboard/joystick merge logic and the game core's INP0/INP1/INP2 ports. It synchronises and debounces every player control, then turns coin presses into a queued train of fixed-width, fixed-gap coin pulses, so that fast or repeated coin presses are never lost or merged. Its outputs drive the core input buses directly, with no further glue.

Parameters:
TICK_DIV, 48000, MCLK cycles per sample tick (1 ms at 48 MHz).
DEB_N, 4, consecutive equal tick samples needed to change a debounced bit (range 2..8).
PULSE_TICKS, 100, ticks the coin output is held high per coin.
GAP_TICKS, 100, minimum low ticks after each coin pulse.
QBITS, 4, width of the pending-coin counter; it saturates at 2^QBITS-1.

Ports:
MCLK  in  1  system clock (48 MHz).
RESET  in  1  synchronous, active-high reset.
IN0_RAW  in  6  P1 {trig2,trig1,left,down,right,up}, active-high, asynchronous.
IN1_RAW  in  6  P2, same bit order as IN0_RAW.
START_RAW  in  2  {start2,start1}, active-high.
COIN_RAW  in  2  {coin2,coin1}, active-high.
INP0  out  6  debounced P1 controls.
INP1  out  6  debounced P2 controls.
INP2  out  3  {coin_pulse, start2, start1}.
COIN_PEND  out  QBITS  number of coins queued and not yet pulsed.
COIN_OVF  out  1  sticky flag: a coin was dropped because the queue was saturated.

Behaviour:
- Reset (synchronous, active-high, at any time including mid-pulse):
  - all synchroniser flops, sample history, debounced values, INP0/INP1/INP2, COIN_PEND and COIN_OVF go to 0;
  - prescaler goes to 0 and the FSM goes to IDLE.
- Synchroniser: 16 raw bits pass through a 2-flop chain on MCLK.
- Tick prescaler:
  - counts 0..TICK_DIV-1;
  - tick is a 1-cycle strobe in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
- Debounce, per bit:
  - on each tick, the synced value shifts into a DEB_N-deep history;
  - the debounced value updates in the cycle after the tick when all DEB_N samples are equal and differ from the current value;
  - pulses shorter than DEB_N-1 ticks never propagate;
  - worst-case latency from a raw edge to the output edge is 2 + DEB_N*TICK_DIV + 1 cycles.
- INP0, INP1 and INP2[1:0] are registered copies of the debounced values.
- Coin edge detect: a rising edge of debounced coin1 or coin2 produces an increment request; simultaneous edges on both request +2.
- Pending counter, per cycle: next = pend + inc - dec.
  - dec = 1 in the cycle the FSM leaves IDLE or GAP for PULSE.
  - inc and dec in the same cycle are applied together (net value).
  - The result saturates at 2^QBITS-1; any coin lost to saturation sets COIN_OVF, which clears only on RESET.
- Coin FSM (tick counter tcnt, counted in ticks):
  - IDLE: INP2[2]=0. If pend>0, go to PULSE with dec=1 and tcnt=0.
  - PULSE: INP2[2]=1. Increment tcnt on each tick; when tcnt reaches PULSE_TICKS-1 and a tick occurs, go to GAP with tcnt=0.
  - GAP: INP2[2]=0. Increment tcnt on each tick; when GAP_TICKS-1 is reached on a tick, go to PULSE with dec=1 if pend>0, else go to IDLE.
  - The PULSE high time is between PULSE_TICKS-1 and PULSE_TICKS ticks, because the phase of the entry tick varies.
  - The coin is decremented from the queue when its pulse starts.
- Start inputs are not queued and are only debounced.

Decomposition:
- Shared package coin_input_pkg holds:
  - the FSM state enum {IDLE, PULSE, GAP};
  - the bit-index constants for the {trig2,trig1,left,down,right,up} layout;
  - the INP2 bit positions (COIN=2, START2=1, START1=0).
- One sub-module, input_debounce, is instantiated per bit or vectorised. It contains the synchroniser, the history and the stable register, with the tick as an input, and is parameterised by DEB_N.
- Prescaler, edge detect, queue and FSM stay in the top.

Test Plan:
Bench parameters: TICK_DIV=4, DEB_N=3, PULSE_TICKS=2, GAP_TICKS=2.
1. Assert RESET, hold IN0_RAW=6'h3F, release RESET → all outputs read 0 while RESET is held. INP0 becomes 6'h3F no later than 2+12+1 cycles after release.
2. IN0_RAW[0] glitches high for 5 cycles (less than 2 ticks) → INP0[0] stays 0. A sustained 20-cycle high → INP0[0]=1.
3. A single COIN_RAW[0] press held for 40 cycles → exactly one INP2[2] high pulse of 4-8 cycles, followed by at least 7 low cycles; COIN_PEND goes 1 then 0.
4. Both coin bits rise in the same cycle → COIN_PEND=2, then two pulses separated by a GAP; COIN_PEND ends at 0.
5. 17 debounced coin presses while the FSM is busy → COIN_PEND saturates at 15 and COIN_OVF=1. After all pulses drain, COIN_PEND=0 and COIN_OVF remains 1 until RESET.
6. Assert RESET mid-PULSE with COIN_PEND=3 → the next cycle shows INP2[2]=0, COIN_PEND=0, COIN_OVF=0, FSM IDLE, and no residual pulse after release.
